// File: rtl/onchip_mem_arbiter_pkg.sv
// Shared constants for the on-chip RAM arbiter: default geometry and requester ids.
package onchip_mem_arbiter_pkg;

  localparam int unsigned ADDR_W_DEF    = 10;
  localparam int unsigned DATA_W_DEF    = 32;
  localparam int unsigned BURST_MAX_DEF = 4;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_GFX = 1'b1;

endpackage

// File: rtl/rr_grant2.sv
// Two-way round-robin grant with a bounded burst hold; state is {last_grant, burst_cnt}.
module rr_grant2
  import onchip_mem_arbiter_pkg::*;
#(
  parameter int unsigned BurstMax = BURST_MAX_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req_i,
  output logic       gnt_any_o,
  output logic       gnt_id_o
);

  localparam int unsigned CntW = $clog2(BurstMax + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(BurstMax);

  logic            last_q, last_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    gnt_any_o = 1'b0;
    gnt_id_o  = last_q;
    case (req_i)
      2'b01: begin
        gnt_any_o = 1'b1;
        gnt_id_o  = PORT_CPU;
      end
      2'b10: begin
        gnt_any_o = 1'b1;
        gnt_id_o  = PORT_GFX;
      end
      2'b11: begin
        gnt_any_o = 1'b1;
        // A zero count means nobody is mid-burst, so rotate to the other port.
        if (cnt_q != '0 && cnt_q < CntMax) begin
          gnt_id_o = last_q;
        end else begin
          gnt_id_o = ~last_q;
        end
      end
      default: gnt_any_o = 1'b0;
    endcase
    if (reset) begin
      gnt_any_o = 1'b0;
    end
  end

  always_comb begin
    last_d = last_q;
    cnt_d  = cnt_q;
    if (!gnt_any_o) begin
      cnt_d = '0;
    end else if (gnt_id_o == last_q) begin
      cnt_d = (cnt_q == CntMax) ? cnt_q : cnt_q + 1'b1;
    end else begin
      cnt_d  = CntW'(1);
      last_d = gnt_id_o;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_q <= PORT_GFX;
      cnt_q  <= '0;
    end else begin
      last_q <= last_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/onchip_mem_arbiter.sv
// Shares a single-port on-chip RAM between the CPU and GFX Avalon-MM masters;
// read returns are steered to their owner by a one-stage tag pipe.
module onchip_mem_arbiter
  import onchip_mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W    = ADDR_W_DEF,
  parameter int unsigned DATA_W    = DATA_W_DEF,
  parameter int unsigned BURST_MAX = BURST_MAX_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   m0_address,
  input  logic [DATA_W/8-1:0] m0_byteenable,
  input  logic                m0_read,
  input  logic                m0_write,
  input  logic [DATA_W-1:0]   m0_writedata,
  output logic                m0_waitrequest,
  output logic [DATA_W-1:0]   m0_readdata,
  output logic                m0_readdatavalid,
  input  logic [ADDR_W-1:0]   m1_address,
  input  logic [DATA_W/8-1:0] m1_byteenable,
  input  logic                m1_read,
  input  logic                m1_write,
  input  logic [DATA_W-1:0]   m1_writedata,
  output logic                m1_waitrequest,
  output logic [DATA_W-1:0]   m1_readdata,
  output logic                m1_readdatavalid,
  output logic [ADDR_W-1:0]   mem_address,
  output logic [DATA_W/8-1:0] mem_byteenable,
  output logic                mem_chipselect,
  output logic                mem_write,
  output logic [DATA_W-1:0]   mem_writedata,
  output logic                mem_clken,
  input  logic [DATA_W-1:0]   mem_readdata
);

  logic [1:0] req;
  logic       gnt_any;
  logic       gnt_id;
  logic       tag_valid_q, tag_valid_d;
  logic       tag_owner_q, tag_owner_d;

  assign req = {m1_read | m1_write, m0_read | m0_write};

  rr_grant2 #(
    .BurstMax(BURST_MAX)
  ) u_rr_grant2 (
    .clk      (clk),
    .reset    (reset),
    .req_i    (req),
    .gnt_any_o(gnt_any),
    .gnt_id_o (gnt_id)
  );

  always_comb begin
    if (gnt_id == PORT_GFX) begin
      mem_address    = m1_address;
      mem_byteenable = m1_byteenable;
      mem_writedata  = m1_writedata;
      mem_write      = gnt_any & m1_write;
    end else begin
      mem_address    = m0_address;
      mem_byteenable = m0_byteenable;
      mem_writedata  = m0_writedata;
      mem_write      = gnt_any & m0_write;
    end
    mem_chipselect = gnt_any;
    mem_clken      = ~reset;
    m0_waitrequest = ~(gnt_any && gnt_id == PORT_CPU);
    m1_waitrequest = ~(gnt_any && gnt_id == PORT_GFX);
  end

  // A write wins over a simultaneous read, so only pure reads earn a return slot.
  always_comb begin
    tag_valid_d = gnt_any & ~mem_write;
    tag_owner_d = gnt_id;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tag_valid_q <= 1'b0;
      tag_owner_q <= PORT_CPU;
    end else begin
      tag_valid_q <= tag_valid_d;
      tag_owner_q <= tag_owner_d;
    end
  end

  // Gating with reset drops a return that was in flight when reset arrived.
  always_comb begin
    m0_readdata      = mem_readdata;
    m1_readdata      = mem_readdata;
    m0_readdatavalid = tag_valid_q & ~reset & (tag_owner_q == PORT_CPU);
    m1_readdatavalid = tag_valid_q & ~reset & (tag_owner_q == PORT_GFX);
  end

endmodule
